alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the ALU interface: accepts one decoded RV32I instruction (fields + operands) via valid/ready,
//  generates ALUop and A/B operands, drives the ALU from registers, captures Y/zero, returns result + branch decision.
//  Sits between decode/register-read and writeback/PC-select; converts the combinational ALU into a handshaked stage.
// PARAMETERS
//  XLEN      32  datapath width; only 32 supported (ALU is fixed 32-bit)
//  ALUOP_W   5   ALUop width; matches ALU encoding
// PORTS
//  clk            in   1      single clock, all state on posedge
//  rst            in   1      synchronous, active-high reset
//  in_valid       in   1      instruction request valid
//  in_ready       out  1      block can accept request
//  in_opcode      in   7      instr[6:0]
//  in_funct3      in   3      instr[14:12]
//  in_funct7      in   7      instr[31:25]
//  in_rs1/in_rs2  in   32     register operands
//  in_imm         in   32     sign-extended immediate from decode
//  in_pc          in   32     instruction PC (AUIPC)
//  alu_a/alu_b    out  32     ALU operands (registered)
//  alu_op         out  5      ALU opcode (registered)
//  alu_y          in   32     ALU result
//  alu_zero       in   1      ALU zero flag (Y==0)
//  out_valid      out  1      result valid
//  out_ready      in   1      consumer accepts result
//  out_result     out  32     captured alu_y
//  out_is_branch  out  1      request was opcode 1100011
//  out_br_taken   out  1      out_is_branch & ~zero
//  out_illegal    out  1      undecodable request (see CONFIGURATION)
// BEHAVIOUR
//  FSM IDLE -> EXEC -> DONE -> IDLE. in_ready = (state==IDLE). out_valid = (state==DONE).
//  IDLE: on in_valid, register alu_op/alu_a/alu_b/is_branch/illegal from decode; go EXEC.
//  EXEC: ALU settles on registered operands; capture alu_y->out_result, alu_zero; go DONE. Exactly 1 cycle.
//  DONE: hold all out_* stable until out_ready; on out_ready go IDLE. Latency: accept at cycle N, out_valid at N+2.
//  Throughput: max one request per 3 cycles; no back-to-back accept from DONE.
//  ALUop map: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 BEQ10 BNE11 BLT12 BGE13 BLTU14 BGEU15; illegal=5'b11111.
//  0110011 R: A=rs1,B=rs2; f3 000 ADD/SUB by f7[5]; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA by f7[5]; 110 OR; 111 AND.
//  0010011 I: A=rs1,B=imm; as R except f3 000 always ADD; f3 101 selects SRA by imm[10].
//  1100011 B: A=rs1,B=rs2; f3 000 BEQ,001 BNE,100 BLT,101 BGE,110 BLTU,111 BGEU; 010/011 illegal.
//  0000011/0100011/1100111 (load/store/JALR): ADD, A=rs1,B=imm.  0110111 LUI: ADD,A=0,B=imm.  0010111 AUIPC: ADD,A=pc,B=imm.
//  Any other opcode: illegal, alu_op=5'b11111, A=B=0 (ALU yields 0, out_result=0, out_br_taken=0).
//  Reset (any state, incl. mid-EXEC/DONE): state=IDLE, all out_* and alu_* = 0; in-flight request dropped.
//  in_* fields sampled only on accept; changes while in_ready=0 ignored.
// CONFIGURATION
//  ALU_ILLEGAL_FLAG_EN defined: out_illegal registered with the request, valid with out_valid, 1 for illegal decodes.
//  Not defined: out_illegal tied 0; illegal requests complete normally with result 0.
// STRUCTURE
//  Package alu_pkg: ALUop localparams (ALU_ADD..ALU_BGEU, ALU_NOP=5'b11111), opcode constants, FSM state enum.
//  Sub-module alu_op_decode: combinational opcode/funct3/funct7/imm -> {alu_op, sel_a, sel_b, is_branch, illegal}.
//  Top holds FSM, operand/result registers; ALU instantiated outside, connected via alu_* ports.
// TESTING
//  R ADD rs1=5 rs2=7, accept cycle 0 -> alu_op=0 cycle 1, out_valid cycle 2, out_result=12, br_taken=0.
//  R SUB f7=0100000 rs1=10 rs2=3 -> alu_op=1, out_result=7; I SRAI imm=0x404 rs1=0x80000000 -> alu_op=7, 0xF8000000.
//  BEQ rs1=rs2=0x55 -> alu_op=10, out_result=1, out_is_branch=1, out_br_taken=1; BNE same -> br_taken=0.
//  Backpressure: out_ready=0 for 3 cycles in DONE -> out_* stable, in_ready=0, new in_valid ignored; then release -> IDLE.
//  Opcode 0x7F -> alu_op=5'b11111, out_result=0; out_illegal=1 with ALU_ILLEGAL_FLAG_EN, 0 without.
//  rst asserted during EXEC -> next cycle IDLE, in_ready=1, out_valid=0, no result delivered.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU opcode encodings, RV32I major opcodes, operand selects and issue FSM states
// shared by the issue controller and its decoder.
package alu_pkg;

  localparam int ALU_XLEN = 32;
  localparam int ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 5'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 5'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 5'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 5'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 5'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 5'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'd9;
  localparam logic [ALU_OP_W-1:0] ALU_BEQ  = 5'd10;
  localparam logic [ALU_OP_W-1:0] ALU_BNE  = 5'd11;
  localparam logic [ALU_OP_W-1:0] ALU_BLT  = 5'd12;
  localparam logic [ALU_OP_W-1:0] ALU_BGE  = 5'd13;
  localparam logic [ALU_OP_W-1:0] ALU_BLTU = 5'd14;
  localparam logic [ALU_OP_W-1:0] ALU_BGEU = 5'd15;
  localparam logic [ALU_OP_W-1:0] ALU_NOP  = 5'b11111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
  typedef enum logic [1:0] {SEL_A_ZERO, SEL_A_RS1, SEL_A_PC} sel_a_t;
  typedef enum logic [1:0] {SEL_B_ZERO, SEL_B_RS2, SEL_B_IMM} sel_b_t;

  // Shared R/I arithmetic table; alt picks SUB or SRA on the two overloaded funct3 codes.
  function automatic logic [ALU_OP_W-1:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I field decode to ALUop, operand selects, branch and illegal flags.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0]          i_opcode,
  input  logic [2:0]          i_funct3,
  input  logic [6:0]          i_funct7,
  input  logic [ALU_XLEN-1:0] i_imm,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output sel_a_t              o_sel_a,
  output sel_b_t              o_sel_b,
  output logic                o_is_branch,
  output logic                o_illegal
);

  logic w_unused;
  assign w_unused = ^{i_funct7[6], i_funct7[4:0], i_imm[31:11], i_imm[9:0]};

  always_comb begin
    o_alu_op    = ALU_NOP;
    o_sel_a     = SEL_A_ZERO;
    o_sel_b     = SEL_B_ZERO;
    o_is_branch = 1'b0;
    o_illegal   = 1'b0;
    case (i_opcode)
      OPC_OP: begin
        o_alu_op = arith_op(i_funct3, i_funct7[5]);
        o_sel_a  = SEL_A_RS1;
        o_sel_b  = SEL_B_RS2;
      end
      OPC_OPIMM: begin
        // Only shifts use the alt bit, taken from the immediate; ADDI never subtracts.
        o_alu_op = arith_op(i_funct3, (i_funct3 == 3'b101) & i_imm[10]);
        o_sel_a  = SEL_A_RS1;
        o_sel_b  = SEL_B_IMM;
      end
      OPC_BRANCH: begin
        o_is_branch = 1'b1;
        case (i_funct3)
          3'b000:  o_alu_op = ALU_BEQ;
          3'b001:  o_alu_op = ALU_BNE;
          3'b100:  o_alu_op = ALU_BLT;
          3'b101:  o_alu_op = ALU_BGE;
          3'b110:  o_alu_op = ALU_BLTU;
          3'b111:  o_alu_op = ALU_BGEU;
          default: o_illegal = 1'b1;
        endcase
        if (o_alu_op != ALU_NOP) begin
          o_sel_a = SEL_A_RS1;
          o_sel_b = SEL_B_RS2;
        end
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        o_alu_op = ALU_ADD;
        o_sel_a  = SEL_A_RS1;
        o_sel_b  = SEL_B_IMM;
      end
      OPC_LUI: begin
        o_alu_op = ALU_ADD;
        o_sel_b  = SEL_B_IMM;
      end
      OPC_AUIPC: begin
        o_alu_op = ALU_ADD;
        o_sel_a  = SEL_A_PC;
        o_sel_b  = SEL_B_IMM;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Handshaked issue stage around an external combinational ALU: accept at N, out_valid at N+2.
// Holds the result until out_ready, one request per 3 cycles; ALU_ILLEGAL_FLAG_EN enables out_illegal.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         in_opcode,
  input  logic [2:0]         in_funct3,
  input  logic [6:0]         in_funct7,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [XLEN-1:0]    in_pc,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [ALUOP_W-1:0] alu_op,
  input  logic [XLEN-1:0]    alu_y,
  input  logic               alu_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic               out_is_branch,
  output logic               out_br_taken,
  output logic               out_illegal
);

  state_t             r_state, w_state_nxt;
  logic               w_accept, w_capture;
  logic [ALUOP_W-1:0] w_dec_op;
  sel_a_t             w_sel_a;
  sel_b_t             w_sel_b;
  logic               w_dec_br, w_dec_ill;
  logic [XLEN-1:0]    w_a, w_b;
  logic [XLEN-1:0]    r_alu_a, r_alu_b, r_result;
  logic [ALUOP_W-1:0] r_alu_op;
  logic               r_is_branch, r_br_taken;

  alu_op_decode u_dec (
    .i_opcode    (in_opcode),
    .i_funct3    (in_funct3),
    .i_funct7    (in_funct7),
    .i_imm       (in_imm),
    .o_alu_op    (w_dec_op),
    .o_sel_a     (w_sel_a),
    .o_sel_b     (w_sel_b),
    .o_is_branch (w_dec_br),
    .o_illegal   (w_dec_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
    w_accept  = (r_state == ST_IDLE) & in_valid;
    w_capture = (r_state == ST_EXEC);
  end

  always_comb begin
    case (w_sel_a)
      SEL_A_RS1: w_a = in_rs1;
      SEL_A_PC:  w_a = in_pc;
      default:   w_a = '0;
    endcase
    case (w_sel_b)
      SEL_B_RS2: w_b = in_rs2;
      SEL_B_IMM: w_b = in_imm;
      default:   w_b = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_is_branch <= 1'b0;
      r_result    <= '0;
      r_br_taken  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_a     <= w_a;
        r_alu_b     <= w_b;
        r_alu_op    <= w_dec_op;
        r_is_branch <= w_dec_br;
      end
      // ALU output has settled on the operands registered at accept.
      if (w_capture) begin
        r_result   <= alu_y;
        r_br_taken <= r_is_branch & ~alu_zero;
      end
    end
  end

  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_op        = r_alu_op;
  assign out_result    = r_result;
  assign out_is_branch = r_is_branch;
  assign out_br_taken  = r_br_taken;

`ifdef ALU_ILLEGAL_FLAG_EN
  logic r_illegal;
  always_ff @(posedge clk) begin
    if (rst)           r_illegal <= 1'b0;
    else if (w_accept) r_illegal <= w_dec_ill;
  end
  assign out_illegal = r_illegal;
`else
  logic w_unused_ill;
  assign w_unused_ill = w_dec_ill;
  assign out_illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [4:0]  alu_op;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_is_branch, out_br_taken, out_illegal;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_is_branch(out_is_branch),
    .out_br_taken(out_br_taken), .out_illegal(out_illegal)
  );

  // Reference combinational ALU standing in for the external unit.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op);
    case (op)
      5'd0:    alu_model = a + b;
      5'd1:    alu_model = a - b;
      5'd2:    alu_model = a << b[4:0];
      5'd3:    alu_model = {31'b0, $signed(a) < $signed(b)};
      5'd4:    alu_model = {31'b0, a < b};
      5'd5:    alu_model = a ^ b;
      5'd6:    alu_model = a >> b[4:0];
      5'd7:    alu_model = $unsigned($signed(a) >>> b[4:0]);
      5'd8:    alu_model = a | b;
      5'd9:    alu_model = a & b;
      5'd10:   alu_model = {31'b0, a == b};
      5'd11:   alu_model = {31'b0, a != b};
      5'd12:   alu_model = {31'b0, $signed(a) < $signed(b)};
      5'd13:   alu_model = {31'b0, $signed(a) >= $signed(b)};
      5'd14:   alu_model = {31'b0, a < b};
      5'd15:   alu_model = {31'b0, a >= b};
      default: alu_model = 32'h0;
    endcase
  endfunction

  always_comb begin
    alu_y    = alu_model(alu_a, alu_b, alu_op);
    alu_zero = (alu_y == 32'h0);
  end

  typedef struct packed {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1, rs2, imm, pc;
    logic [4:0]  e_op;
    logic [31:0] e_a, e_b, e_res;
    logic        e_isbr, e_tk, e_ill;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready got %0b want 1", in_ready); end
    n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid got %0b want 0", out_valid); end
    n_total++; if (alu_op !== 5'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      n_bad++; $display("FAIL reset alu got op=%0h a=%0h b=%0h want 0", alu_op, alu_a, alu_b); end
    n_total++; if (out_result !== 32'd0 || out_is_branch !== 1'b0 || out_br_taken !== 1'b0 || out_illegal !== 1'b0) begin
      n_bad++; $display("FAIL reset out got res=%0h br=%0b tk=%0b ill=%0b want 0", out_result, out_is_branch, out_br_taken, out_illegal); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_decode();
    vecs[0]  = '{7'h33, 3'd0, 7'h00, 32'd5,        32'd7,        32'h0,        32'h0,   5'd0,  32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1'b0};
    vecs[1]  = '{7'h33, 3'd0, 7'h20, 32'd10,       32'd3,        32'h0,        32'h0,   5'd1,  32'd10,       32'd3,        32'd7,        1'b0, 1'b0, 1'b0};
    vecs[2]  = '{7'h13, 3'd5, 7'h20, 32'h80000000, 32'h0,        32'h404,      32'h0,   5'd7,  32'h80000000, 32'h404,      32'hF8000000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{7'h13, 3'd5, 7'h00, 32'h80000000, 32'h0,        32'h4,        32'h0,   5'd6,  32'h80000000, 32'h4,        32'h08000000, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{7'h13, 3'd0, 7'h20, 32'd10,       32'h0,        32'hFFFFFFFF, 32'h0,   5'd0,  32'd10,       32'hFFFFFFFF, 32'd9,        1'b0, 1'b0, 1'b0};
    vecs[5]  = '{7'h33, 3'd3, 7'h00, 32'd1,        32'hFFFFFFFF, 32'h0,        32'h0,   5'd4,  32'd1,        32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 1'b0};
    vecs[6]  = '{7'h33, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,   5'd3,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0};
    vecs[7]  = '{7'h33, 3'd1, 7'h00, 32'd1,        32'd5,        32'h0,        32'h0,   5'd2,  32'd1,        32'd5,        32'd32,       1'b0, 1'b0, 1'b0};
    vecs[8]  = '{7'h13, 3'd6, 7'h00, 32'hF0,       32'h0,        32'h0F,       32'h0,   5'd8,  32'hF0,       32'h0F,       32'hFF,       1'b0, 1'b0, 1'b0};
    vecs[9]  = '{7'h33, 3'd7, 7'h00, 32'hFF,       32'h0F,       32'h0,        32'h0,   5'd9,  32'hFF,       32'h0F,       32'h0F,       1'b0, 1'b0, 1'b0};
    vecs[10] = '{7'h33, 3'd4, 7'h00, 32'hF0F0,     32'h0FF0,     32'h0,        32'h0,   5'd5,  32'hF0F0,     32'h0FF0,     32'hFF00,     1'b0, 1'b0, 1'b0};
    vecs[11] = '{7'h63, 3'd0, 7'h00, 32'h55,       32'h55,       32'h0,        32'h0,   5'd10, 32'h55,       32'h55,       32'd1,        1'b1, 1'b1, 1'b0};
    vecs[12] = '{7'h63, 3'd1, 7'h00, 32'h55,       32'h55,       32'h0,        32'h0,   5'd11, 32'h55,       32'h55,       32'd0,        1'b1, 1'b0, 1'b0};
    vecs[13] = '{7'h63, 3'd6, 7'h00, 32'd2,        32'd3,        32'h0,        32'h0,   5'd14, 32'd2,        32'd3,        32'd1,        1'b1, 1'b1, 1'b0};
    vecs[14] = '{7'h63, 3'd5, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,   5'd13, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b0};
    vecs[15] = '{7'h37, 3'd0, 7'h00, 32'hDEAD,     32'hBEEF,     32'h12345000, 32'h0,   5'd0,  32'h0,        32'h12345000, 32'h12345000, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{7'h17, 3'd0, 7'h00, 32'h999,      32'h0,        32'h2000,     32'h100, 5'd0,  32'h100,      32'h2000,     32'h2100,     1'b0, 1'b0, 1'b0};
    vecs[17] = '{7'h03, 3'd2, 7'h00, 32'h1000,     32'h0,        32'hFFFFFFFC, 32'h0,   5'd0,  32'h1000,     32'hFFFFFFFC, 32'hFFC,      1'b0, 1'b0, 1'b0};
    vecs[18] = '{7'h67, 3'd0, 7'h00, 32'h40,       32'h0,        32'h8,        32'h0,   5'd0,  32'h40,       32'h8,        32'h48,       1'b0, 1'b0, 1'b0};
    vecs[19] = '{7'h63, 3'd2, 7'h00, 32'd1,        32'd2,        32'h0,        32'h0,   5'd31, 32'h0,        32'h0,        32'd0,        1'b1, 1'b0, 1'b1};
    vecs[20] = '{7'h7F, 3'd0, 7'h00, 32'h1234,     32'h5678,     32'h9ABC,     32'h10,  5'd31, 32'h0,        32'h0,        32'd0,        1'b0, 1'b0, 1'b1};
    vecs[21] = '{7'h23, 3'd2, 7'h00, 32'h200,      32'h7,        32'h10,       32'h0,   5'd0,  32'h200,      32'h10,       32'h210,      1'b0, 1'b0, 1'b0};
    for (int i = 0; i < NV; i++) begin
      logic exp_ill;
`ifdef ALU_ILLEGAL_FLAG_EN
      exp_ill = vecs[i].e_ill;
`else
      exp_ill = 1'b0;
`endif
      @(negedge clk);
      in_opcode = vecs[i].opc; in_funct3 = vecs[i].f3; in_funct7 = vecs[i].f7;
      in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2; in_imm = vecs[i].imm; in_pc = vecs[i].pc;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_total++; if (alu_op !== vecs[i].e_op) begin n_bad++; $display("FAIL vec%0d alu_op got %0d want %0d", i, alu_op, vecs[i].e_op); end
      n_total++; if (alu_a !== vecs[i].e_a || alu_b !== vecs[i].e_b) begin
        n_bad++; $display("FAIL vec%0d operands got a=%0h b=%0h want a=%0h b=%0h", i, alu_a, alu_b, vecs[i].e_a, vecs[i].e_b); end
      n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_bad++; $display("FAIL vec%0d exec handshake got out_valid=%0b in_ready=%0b want 0 0", i, out_valid, in_ready); end
      @(posedge clk); #1;
      n_total++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL vec%0d out_valid got %0b want 1", i, out_valid); end
      n_total++; if (out_result !== vecs[i].e_res) begin n_bad++; $display("FAIL vec%0d out_result got %0h want %0h", i, out_result, vecs[i].e_res); end
      n_total++; if (out_is_branch !== vecs[i].e_isbr || out_br_taken !== vecs[i].e_tk) begin
        n_bad++; $display("FAIL vec%0d branch got br=%0b tk=%0b want br=%0b tk=%0b", i, out_is_branch, out_br_taken, vecs[i].e_isbr, vecs[i].e_tk); end
      n_total++; if (out_illegal !== exp_ill) begin n_bad++; $display("FAIL vec%0d out_illegal got %0b want %0b", i, out_illegal, exp_ill); end
      @(posedge clk); #1;
      n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_bad++; $display("FAIL vec%0d return idle got in_ready=%0b out_valid=%0b want 1 0", i, in_ready, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    in_opcode = 7'h33; in_funct3 = 3'd4; in_funct7 = 7'h00;
    in_rs1 = 32'hA5A5A5A5; in_rs2 = 32'h0000FFFF; in_imm = 32'h0; in_pc = 32'h0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b1 || out_result !== 32'hA5A55A5A) begin
      n_bad++; $display("FAIL bp first got out_valid=%0b res=%0h want 1 a5a55a5a", out_valid, out_result); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_opcode = 7'h33; in_funct3 = 3'd0; in_rs1 = 32'd1; in_rs2 = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      n_total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp hold%0d got out_valid=%0b in_ready=%0b want 1 0", c, out_valid, in_ready); end
      n_total++; if (out_result !== 32'hA5A55A5A || out_is_branch !== 1'b0 || out_br_taken !== 1'b0) begin
        n_bad++; $display("FAIL bp stable%0d got res=%0h br=%0b tk=%0b want a5a55a5a 0 0", c, out_result, out_is_branch, out_br_taken); end
      n_total++; if (alu_op !== 5'd5 || alu_a !== 32'hA5A5A5A5) begin
        n_bad++; $display("FAIL bp ignore%0d got op=%0d a=%0h want 5 a5a5a5a5", c, alu_op, alu_a); end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp release got in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid); end
    @(posedge clk); #1;
    n_total++; if (in_ready !== 1'b1 || alu_op !== 5'd5) begin
      n_bad++; $display("FAIL bp no_accept got in_ready=%0b op=%0d want 1 5", in_ready, alu_op); end
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk);
    in_opcode = 7'h33; in_funct3 = 3'd0; in_funct7 = 7'h00;
    in_rs1 = 32'd100; in_rs2 = 32'd200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++; if (in_ready !== 1'b0 || alu_a !== 32'd100) begin
      n_bad++; $display("FAIL rst_exec pre got in_ready=%0b a=%0d want 0 100", in_ready, alu_a); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_exec idle got in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid); end
    n_total++; if (out_result !== 32'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 5'd0) begin
      n_bad++; $display("FAIL rst_exec clear got res=%0h a=%0h b=%0h op=%0d want 0", out_result, alu_a, alu_b, alu_op); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_total++; if (out_valid !== 1'b0 || out_result !== 32'd0) begin
        n_bad++; $display("FAIL rst_exec dropped%0d got out_valid=%0b res=%0h want 0 0", c, out_valid, out_result); end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
